alu_op_sequencer: RTL and testbench

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 149 ++++++++++++++
 tb/tb_alu_op_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Command sequencer for an external ALU. Commands are queued in a small
// FIFO, issued one at a time with a single-cycle execute strobe, given one
// settle cycle, and result-producing opcodes are captured and held until
// the consumer accepts them.
module alu_op_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic [3:0] alu_sel,
    output logic [7:0] alu_data,
    output logic       alu_en,
    input  logic [7:0] alu_y,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic [3:0] res_op,
    output logic       busy,
    output logic [3:0] fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // Opcodes above this value are register moves/swaps/loads with no result.
    localparam logic [3:0] LAST_RESULT_OP = 4'd12;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        HOLD
    } state_t;

    state_t           state_reg, state_next;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [3:0]       count_reg;
    logic [3:0]       op_mem   [FIFO_DEPTH];
    logic [7:0]       data_mem [FIFO_DEPTH];
    logic [3:0]       alu_sel_reg;
    logic [7:0]       alu_data_reg;
    logic             res_valid_reg;
    logic [7:0]       res_data_reg;
    logic [3:0]       res_op_reg;
    logic             push;
    logic             pop;
    logic             start_issue;

    // Ready depends only on registered occupancy, so a pop in the same cycle
    // never opens the door for a push into a full FIFO.
    assign cmd_ready   = (count_reg < 4'(FIFO_DEPTH));
    assign push        = cmd_valid && cmd_ready;
    assign pop         = (state_reg == ISSUE);
    assign start_issue = (state_reg == IDLE) && (count_reg != 4'd0);

    // Command storage: plain array, no reset, written at the tail.
    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_ptr_reg]   <= cmd_op;
            data_mem[wr_ptr_reg] <= cmd_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= 4'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 4'd1;
                2'b01:   count_reg <= count_reg - 4'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (count_reg != 4'd0) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    state_next = CAPTURE;
            CAPTURE: state_next = (alu_sel_reg <= LAST_RESULT_OP) ? HOLD : IDLE;
            HOLD:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FIFO head is read into the ALU drive registers on entry to ISSUE and
    // held there until the next command is issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_sel_reg  <= 4'd0;
            alu_data_reg <= 8'd0;
        end else if (start_issue) begin
            alu_sel_reg  <= op_mem[rd_ptr_reg];
            alu_data_reg <= data_mem[rd_ptr_reg];
        end
    end

    // Result capture at the end of CAPTURE; released by the consumer in HOLD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid_reg <= 1'b0;
            res_data_reg  <= 8'd0;
            res_op_reg    <= 4'd0;
        end else begin
            if (state_reg == CAPTURE && alu_sel_reg <= LAST_RESULT_OP) begin
                res_valid_reg <= 1'b1;
                res_data_reg  <= alu_y;
                res_op_reg    <= alu_sel_reg;
            end else if (state_reg == HOLD && res_ready) begin
                res_valid_reg <= 1'b0;
            end
        end
    end

    assign alu_en     = (state_reg == ISSUE);
    assign alu_sel    = alu_sel_reg;
    assign alu_data   = alu_data_reg;
    assign res_valid  = res_valid_reg;
    assign res_data   = res_data_reg;
    assign res_op     = res_op_reg;
    assign fifo_count = count_reg;
    assign busy       = (state_reg != IDLE) || (count_reg != 4'd0);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU and scoreboard
// queues for issued commands and expected results.
module tb_alu_op_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = 4'd0;
    logic [7:0] cmd_data = 8'd0;
    logic [3:0] alu_sel;
    logic [7:0] alu_data;
    logic       alu_en;
    logic [7:0] alu_y;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic [3:0] res_op;
    logic       busy;
    logic [3:0] fifo_count;

    int n_checks = 0;
    int n_errors = 0;
    int n_results = 0;

    logic [11:0] issue_q[$];
    logic [11:0] res_q[$];

    always #5 clk = ~clk;

    // Behavioural ALU: op 0 with data 5 yields 0x0C.
    function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] d);
        return (d ^ {op, 4'h0}) + 8'd7;
    endfunction

    assign alu_y = alu_f(alu_sel, alu_data);

    alu_op_sequencer #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .alu_sel    (alu_sel),
        .alu_data   (alu_data),
        .alu_en     (alu_en),
        .alu_y      (alu_y),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_op     (res_op),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: record accepted pushes, compare issues and delivered results.
    task automatic observe();
        logic [11:0] e;
        if (cmd_valid && cmd_ready && !reset) begin
            issue_q.push_back({cmd_op, cmd_data});
            if (cmd_op <= 4'd12) res_q.push_back({cmd_op, alu_f(cmd_op, cmd_data)});
            $display("push op=%0h data=%0h", cmd_op, cmd_data);
        end
        if (alu_en) begin
            if (issue_q.size() == 0) begin
                check("alu_en_unexpected", 32'd1, 32'd0);
            end else begin
                e = issue_q.pop_front();
                check("issue_sel", 32'(alu_sel), 32'(e[11:8]));
                check("issue_data", 32'(alu_data), 32'(e[7:0]));
                $display("issue sel=%0h data=%0h", alu_sel, alu_data);
            end
        end
        if (res_valid && res_ready) begin
            n_results++;
            if (res_q.size() == 0) begin
                check("result_unexpected", 32'd1, 32'd0);
            end else begin
                e = res_q.pop_front();
                check("result_op", 32'(res_op), 32'(e[11:8]));
                check("result_data", 32'(res_data), 32'(e[7:0]));
                $display("result op=%0h data=%0h", res_op, res_data);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [3:0] op, input logic [7:0] d);
        logic acc;
        int k;
        cmd_op = op;
        cmd_data = d;
        cmd_valid = 1'b1;
        k = 0;
        acc = 1'b0;
        while (!acc && k < 60) begin
            acc = cmd_ready;
            tick();
            k++;
        end
        if (!acc) check("push_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        res_ready = 1'b1;
        k = 0;
        while ((busy || issue_q.size() != 0) && k < 400) begin
            tick();
            k++;
        end
        check("drain_busy", 32'(busy), 32'd0);
    endtask

    // Single command latency: push at E0, strobe after E1, result at E4.
    task automatic lat_test(input logic [3:0] op, input logic [7:0] d, input logic [7:0] y);
        res_ready = 1'b1;
        push_cmd(op, d);
        check("lat_e0_alu_en", 32'(alu_en), 32'd0);
        check("lat_e0_count", 32'(fifo_count), 32'd1);
        check("lat_e0_busy", 32'(busy), 32'd1);
        tick();
        check("lat_e1_alu_en", 32'(alu_en), 32'd1);
        check("lat_e1_alu_sel", 32'(alu_sel), 32'(op));
        tick();
        check("lat_e2_alu_en", 32'(alu_en), 32'd0);
        check("lat_e2_count", 32'(fifo_count), 32'd0);
        tick();
        check("lat_e3_res_valid", 32'(res_valid), 32'd0);
        tick();
        check("lat_e4_res_valid", 32'(res_valid), 32'd1);
        check("lat_e4_res_data", 32'(res_data), 32'(y));
        check("lat_e4_res_op", 32'(res_op), 32'(op));
        tick();
        check("lat_e5_res_valid", 32'(res_valid), 32'd0);
        check("lat_e5_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] d0;
        logic [3:0] op0;
        int base;

        // Reset state
        tick();
        tick();
        check("rst_alu_en", 32'(alu_en), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu_sel", 32'(alu_sel), 32'd0);
        check("rst_alu_data", 32'(alu_data), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_op", 32'(res_op), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        reset = 1'b0;
        tick();

        // Single add
        lat_test(4'h0, 8'h05, 8'h0C);

        // No-result op
        push_cmd(4'hF, 8'hF3);
        tick();
        check("nores_alu_en", 32'(alu_en), 32'd1);
        check("nores_alu_data", 32'(alu_data), 32'hF3);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("nores_res_valid", 32'(res_valid), 32'd0);
        end
        check("nores_idle", 32'(busy), 32'd0);

        // Fill with backpressure, then hold in HOLD for 10 cycles
        res_ready = 1'b0;
        base = n_results;
        for (int i = 1; i <= 5; i++) push_cmd(4'(i), 8'(8'h10 + i));
        check("fill_count", 32'(fifo_count), 32'd4);
        check("fill_cmd_ready", 32'(cmd_ready), 32'd0);
        check("fill_res_valid", 32'(res_valid), 32'd1);
        check("fill_res_data", 32'(res_data), 32'(alu_f(4'd1, 8'h11)));
        d0 = res_data;
        op0 = res_op;
        cmd_op = 4'd6;
        cmd_data = 8'h60;
        cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_res_data", 32'(res_data), 32'(d0));
            check("hold_res_op", 32'(res_op), 32'(op0));
            check("hold_alu_en", 32'(alu_en), 32'd0);
            check("hold_count", 32'(fifo_count), 32'd4);
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
        end
        res_ready = 1'b1;
        push_cmd(4'd6, 8'h60);
        drain();
        check("fill_results", 32'(n_results - base), 32'd6);
        check("fill_final_count", 32'(fifo_count), 32'd0);
        check("fill_res_q_empty", 32'(res_q.size()), 32'd0);

        // Wrap: nine commands through a depth-4 FIFO
        base = n_results;
        res_ready = 1'b1;
        for (int i = 1; i <= 9; i++) push_cmd(4'(i - 1), 8'(i));
        drain();
        check("wrap_results", 32'(n_results - base), 32'd9);
        check("wrap_final_count", 32'(fifo_count), 32'd0);

        // Async reset during WAIT with three commands queued
        res_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push_cmd(4'(i + 1), 8'(8'h20 + i));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tick();
        check("pre_rst_alu_en", 32'(alu_en), 32'd1);
        tick();
        check("pre_rst_count", 32'(fifo_count), 32'd3);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_alu_en", 32'(alu_en), 32'd0);
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        issue_q.delete();
        res_q.delete();
        tick();
        tick();
        reset = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("post_rst_alu_en", 32'(alu_en), 32'd0);
            check("post_rst_res_valid", 32'(res_valid), 32'd0);
        end

        // First push after reset follows the same latency
        lat_test(4'h3, 8'h40, 8'h77);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
